// File: rtl/lane_dmem_bank.sv
// Lane data-memory bank: in-order request queue, one pop per cycle, single-ported
// memory and a fixed-latency load return pipe.
module lane_dmem_bank #(
    parameter int DEPTH   = 1024,
    parameter int Q_DEPTH = 4,
    parameter int RD_LAT  = 1,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              I_Ld_Req,
    input  logic              I_St_Req,
    input  logic [ADDR_W-1:0] I_Address,
    input  logic [DATA_W-1:0] I_St_Data,
    input  logic              I_Stall,
    output logic              O_Ack_Ld,
    output logic [DATA_W-1:0] O_Ld_Data,
    output logic              O_Full,
    output logic              O_Busy,
    output logic              O_Err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              q_st_q   [Q_DEPTH];
    logic [ADDR_W-1:0] q_addr_q [Q_DEPTH];
    logic [DATA_W-1:0] q_data_q [Q_DEPTH];
    logic [DATA_W-1:0] mem_q    [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic [RD_LAT:0]   vld_q;
    logic [DATA_W-1:0] ld_data_q [RD_LAT+1];

    logic              push, pop, collide;
    logic              head_st, head_oor;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [IDX_W-1:0]  head_idx;

    // Full is judged on the pre-edge count, so a pop cannot make room for a same-cycle push.
    assign O_Full    = (count_q == CNT_W'(Q_DEPTH));
    assign push      = (I_Ld_Req | I_St_Req) & ~O_Full;
    assign collide   = I_Ld_Req & I_St_Req & ~O_Full;
    assign pop       = (count_q != '0) & ~I_Stall;

    assign head_st   = q_st_q[rd_ptr_q];
    assign head_addr = q_addr_q[rd_ptr_q];
    assign head_data = q_data_q[rd_ptr_q];
    assign head_idx  = head_addr[IDX_W-1:0];
    assign head_oor  = |head_addr[ADDR_W-1:IDX_W];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = collide | (pop & head_oor);
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push & ~pop)      count_d = count_q + CNT_W'(1);
        else if (pop & ~push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            vld_q    <= {vld_q[RD_LAT-1:0], pop & ~head_st};
        end
    end

    // Queue payload, memory array and load data carry no reset; validity lives in the control regs.
    always_ff @(posedge clock) begin
        if (push) begin
            q_st_q[wr_ptr_q]   <= I_St_Req;
            q_addr_q[wr_ptr_q] <= I_Address;
            q_data_q[wr_ptr_q] <= I_St_Data;
        end
        if (pop & head_st & ~head_oor)
            mem_q[head_idx] <= head_data;
        if (pop & ~head_st)
            ld_data_q[0] <= head_oor ? '0 : mem_q[head_idx];
        for (int i = 1; i <= RD_LAT; i++)
            ld_data_q[i] <= ld_data_q[i-1];
    end

    assign O_Ack_Ld  = vld_q[RD_LAT];
    assign O_Ld_Data = vld_q[RD_LAT] ? ld_data_q[RD_LAT] : '0;
    assign O_Busy    = (count_q != '0) | (|vld_q);
    assign O_Err     = err_q;
endmodule

// File: tb/tb_lane_dmem_bank.sv
// Bench for lane_dmem_bank: directed scenarios plus randomized traffic against a queue-based model.
module tb_lane_dmem_bank;
    localparam int DEPTH = 1024;
    localparam int QD    = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        I_Ld_Req = 1'b0, I_St_Req = 1'b0, I_Stall = 1'b0;
    logic [31:0] I_Address = '0, I_St_Data = '0;
    logic        ack1, full1, busy1, err1, ack3, full3, busy3, err3;
    logic [31:0] data1, data3;

    always #5 clock = ~clock;

    lane_dmem_bank #(.DEPTH(DEPTH), .Q_DEPTH(QD), .RD_LAT(1), .DATA_W(32), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset), .I_Ld_Req(I_Ld_Req), .I_St_Req(I_St_Req),
        .I_Address(I_Address), .I_St_Data(I_St_Data), .I_Stall(I_Stall),
        .O_Ack_Ld(ack1), .O_Ld_Data(data1), .O_Full(full1), .O_Busy(busy1), .O_Err(err1));

    lane_dmem_bank #(.DEPTH(DEPTH), .Q_DEPTH(QD), .RD_LAT(3), .DATA_W(32), .ADDR_W(32)) dut3 (
        .clock(clock), .reset(reset), .I_Ld_Req(I_Ld_Req), .I_St_Req(I_St_Req),
        .I_Address(I_Address), .I_St_Data(I_St_Data), .I_Stall(I_Stall),
        .O_Ack_Ld(ack3), .O_Ld_Data(data3), .O_Full(full3), .O_Busy(busy3), .O_Err(err3));

    int checks = 0;
    int errors = 0;

    typedef struct { logic st; logic [31:0] addr; logic [31:0] data; } req_t;
    typedef struct { longint due; logic [31:0] data; } pend_t;
    req_t        mq[$];
    pend_t       p1[$], p3[$];
    logic [31:0] mmem [int];
    longint      edge_n = 0;
    logic        exp_ack1, exp_ack3, exp_err, exp_full, exp_busy1, exp_busy3;
    logic [31:0] exp_data1, exp_data3;

    // Drive one cycle of inputs, advance the model across the edge, return just after the edge.
    task automatic step(input logic ld, input logic st, input logic [31:0] a,
                        input logic [31:0] d, input logic stall);
        req_t  h;
        pend_t pe;
        logic  full, oor;
        @(negedge clock);
        I_Ld_Req = ld; I_St_Req = st; I_Address = a; I_St_Data = d; I_Stall = stall;
        full    = (mq.size() == QD);
        exp_err = 1'b0;
        edge_n++;
        if (mq.size() > 0 && !stall) begin
            h   = mq.pop_front();
            oor = (h.addr >= DEPTH);
            if (oor) exp_err = 1'b1;
            if (h.st) begin
                if (!oor) mmem[int'(h.addr)] = h.data;
            end else begin
                if (oor) pe.data = '0;
                else if (mmem.exists(int'(h.addr))) pe.data = mmem[int'(h.addr)];
                else pe.data = 'x;
                pe.due = edge_n + 1; p1.push_back(pe);
                pe.due = edge_n + 3; p3.push_back(pe);
            end
        end
        if ((ld || st) && !full) begin
            h.st = st; h.addr = a; h.data = d;
            mq.push_back(h);
            if (ld && st) exp_err = 1'b1;
        end
        exp_full  = (mq.size() == QD);
        exp_busy1 = (mq.size() != 0) || (p1.size() != 0);
        exp_busy3 = (mq.size() != 0) || (p3.size() != 0);
        exp_ack1 = 1'b0; exp_data1 = '0;
        if (p1.size() != 0 && p1[0].due == edge_n) begin
            exp_ack1 = 1'b1; exp_data1 = p1[0].data; void'(p1.pop_front());
        end
        exp_ack3 = 1'b0; exp_data3 = '0;
        if (p3.size() != 0 && p3[0].due == edge_n) begin
            exp_ack3 = 1'b1; exp_data3 = p3[0].data; void'(p3.pop_front());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({ack1, full1, busy1, err1, data1} !== 36'h0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", {ack1, full1, busy1, err1, data1});
        end
        checks++;
        if ({ack3, full3, busy3, err3, data3} !== 36'h0) begin
            errors++; $display("FAIL reset_outputs_lat3: got %h expected 0", {ack3, full3, busy3, err3, data3});
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_raw();
        step(0, 1, 5, 32'hDEADBEEF, 0);
        step(1, 0, 5, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (ack1 !== 1'b0) begin errors++; $display("FAIL raw_early_ack: got %b expected 0", ack1); end
        step(0, 0, 0, 0, 0);
        checks++;
        if (ack1 !== 1'b1 || data1 !== 32'hDEADBEEF || err1 !== 1'b0) begin
            errors++; $display("FAIL raw_ack: got ack=%b data=%h err=%b expected 1 deadbeef 0", ack1, data1, err1);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (ack1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL raw_after: got ack=%b busy=%b expected 0 0", ack1, busy1);
        end
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) step(0, 1, k, 32'h100 + k, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(1, 0, k, 0, 1);
        checks++;
        if (full1 !== 1'b1) begin errors++; $display("FAIL full_set: got %b expected 1", full1); end
        step(1, 0, 9, 0, 1);
        checks++;
        if (full1 !== 1'b1 || ack1 !== 1'b0) begin
            errors++; $display("FAIL full_hold: got full=%b ack=%b expected 1 0", full1, ack1);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 0);
            if (i == 0) begin
                checks++;
                if (full1 !== 1'b0) begin errors++; $display("FAIL full_release: got %b expected 0", full1); end
            end
            checks++;
            if (i >= 1 && i <= 4) begin
                if (ack1 !== 1'b1 || data1 !== 32'h100 + 32'(i - 1)) begin
                    errors++; $display("FAIL drain_ack%0d: got ack=%b data=%h expected 1 %h", i, ack1, data1, 32'h100 + 32'(i - 1));
                end
            end else if (ack1 !== 1'b0) begin
                errors++; $display("FAIL drain_noack%0d: got %b expected 0", i, ack1);
            end
        end
    endtask

    task automatic test_collision();
        step(1, 1, 7, 32'h11, 0);
        checks++;
        if (err1 !== 1'b1) begin errors++; $display("FAIL coll_err: got %b expected 1", err1); end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            checks++;
            if (ack1 !== 1'b0 || err1 !== 1'b0) begin
                errors++; $display("FAIL coll_quiet%0d: got ack=%b err=%b expected 0 0", i, ack1, err1);
            end
        end
        step(1, 0, 7, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (ack1 !== 1'b1 || data1 !== 32'h11) begin
            errors++; $display("FAIL coll_reload: got ack=%b data=%h expected 1 00000011", ack1, data1);
        end
    endtask

    task automatic test_oor();
        step(1, 0, 1024, 0, 0);
        checks++;
        if (err1 !== 1'b0) begin errors++; $display("FAIL oor_early_err: got %b expected 0", err1); end
        step(0, 0, 0, 0, 0);
        checks++;
        if (err1 !== 1'b1) begin errors++; $display("FAIL oor_ld_err: got %b expected 1", err1); end
        step(0, 0, 0, 0, 0);
        checks++;
        if (ack1 !== 1'b1 || data1 !== 32'h0 || err1 !== 1'b0) begin
            errors++; $display("FAIL oor_ld_ack: got ack=%b data=%h err=%b expected 1 0 0", ack1, data1, err1);
        end
        step(0, 1, 2048, 32'hBAD0BAD0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (err1 !== 1'b1) begin errors++; $display("FAIL oor_st_err: got %b expected 1", err1); end
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (ack1 !== 1'b1 || data1 !== 32'h100) begin
            errors++; $display("FAIL oor_st_dropped: got ack=%b data=%h expected 1 00000100", ack1, data1);
        end
    endtask

    task automatic test_reset_midop();
        step(1, 0, 1, 0, 1);
        step(1, 0, 2, 0, 1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if ({busy1, full1, ack1, busy3, full3, ack3} !== 6'b0) begin
            errors++; $display("FAIL midop_reset: got %b expected 000000", {busy1, full1, ack1, busy3, full3, ack3});
        end
        mq.delete(); p1.delete(); p3.delete();
        repeat (2) @(negedge clock);
        I_Stall = 1'b0; I_Ld_Req = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 0);
            checks++;
            if ({ack1, ack3, busy1, busy3} !== 4'b0) begin
                errors++; $display("FAIL midop_after%0d: got %b expected 0000", i, {ack1, ack3, busy1, busy3});
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 16; k++) step(0, 1, k, 32'hA000_0000 + k, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 22; i++) begin
            step(i < 16, 0, i, 0, 0);
            checks++;
            if (full3 !== 1'b0) begin errors++; $display("FAIL b2b_full%0d: got %b expected 0", i, full3); end
            checks++;
            if (i >= 4 && i < 20) begin
                if (ack3 !== 1'b1 || data3 !== 32'hA000_0000 + 32'(i - 4)) begin
                    errors++; $display("FAIL b2b_ack%0d: got ack=%b data=%h expected 1 %h", i, ack3, data3, 32'hA000_0000 + 32'(i - 4));
                end
            end else if (ack3 !== 1'b0) begin
                errors++; $display("FAIL b2b_noack%0d: got %b expected 0", i, ack3);
            end
        end
    endtask

    task automatic test_random();
        logic        ld, st, stall;
        logic [31:0] a;
        int          r;
        for (int n = 0; n < 400; n++) begin
            ld    = ($urandom_range(0, 9) < 4);
            st    = ($urandom_range(0, 9) < 4);
            stall = ($urandom_range(0, 3) == 0);
            r     = $urandom_range(0, 19);
            a     = (r < 16) ? 32'(r) : 32'(1024 * (r - 15));
            step(ld, st, a, $urandom, stall);
            checks++;
            if (ack1 !== exp_ack1 || err1 !== exp_err || full1 !== exp_full || busy1 !== exp_busy1 ||
                (exp_ack1 && !$isunknown(exp_data1) && data1 !== exp_data1)) begin
                errors++;
                $display("FAIL rand_lat1 cyc%0d: got ack=%b err=%b full=%b busy=%b data=%h expected %b %b %b %b %h",
                         n, ack1, err1, full1, busy1, data1, exp_ack1, exp_err, exp_full, exp_busy1, exp_data1);
            end
            checks++;
            if (ack3 !== exp_ack3 || err3 !== exp_err || full3 !== exp_full || busy3 !== exp_busy3 ||
                (exp_ack3 && !$isunknown(exp_data3) && data3 !== exp_data3)) begin
                errors++;
                $display("FAIL rand_lat3 cyc%0d: got ack=%b err=%b full=%b busy=%b data=%h expected %b %b %b %b %h",
                         n, ack3, err3, full3, busy3, data3, exp_ack3, exp_err, exp_full, exp_busy3, exp_data3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_full();
        test_collision();
        test_oor();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
